// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: takes bytes from uart_receiver, parses SYNC/LEN/payload/CSUM frames,
// holds each good frame for a valid/ack consumer and flags dropped frames with 1-cycle pulses.
module uart_rx_frame_ctrl #(
   parameter logic [7:0]  SYNC_BYTE     = 8'hA5,
   parameter int          MAX_LEN       = 8,
   parameter logic [15:0] TIMEOUT_TICKS = 16'd2560
) (
   input  logic       i_sys_clk,
   input  logic       i_rst_n,
   input  logic       i_rx_clk_en,
   input  logic [7:0] i_rx_data,
   input  logic       i_rx_ready,
   output logic       o_rx_ready_clear,
   output logic       o_frame_valid,
   output logic [3:0] o_frame_len,
   input  logic [2:0] i_frame_rd_addr,
   output logic [7:0] o_frame_rd_data,
   input  logic       i_frame_ack,
   output logic       o_csum_err,
   output logic       o_timeout_err,
   output logic       o_overrun_err
);
   typedef enum logic [2:0] {HUNT, LEN, PAY, CSUM, DONE} state_t;
   localparam logic [7:0] MAX_B = 8'(MAX_LEN);
   state_t      r_state, w_next;
   logic        r_consumed, r_csum_err, r_tout_err, r_ovr_err;
   logic [3:0]  r_len;
   logic [2:0]  r_idx;
   logic [7:0]  r_acc;
   logic [15:0] r_tcnt;
   logic [7:0]  r_buf [8];
   logic        w_new, w_timed, w_tout, w_len_ok, w_last, w_csum_ok;
   assign w_new     = i_rx_ready & ~r_consumed;
   assign w_timed   = r_state inside {LEN, PAY, CSUM};
   // a byte arriving on the expiry edge wins over the timeout
   assign w_tout    = w_timed & ~w_new & i_rx_clk_en & (r_tcnt == TIMEOUT_TICKS - 16'd1);
   assign w_len_ok  = (i_rx_data != 8'd0) && (i_rx_data <= MAX_B);
   assign w_last    = {1'b0, r_idx} == r_len - 4'd1;
   assign w_csum_ok = i_rx_data == r_acc;
   always_ff @(posedge i_sys_clk) begin
      if (!i_rst_n) r_state <= HUNT;
      else          r_state <= w_next;
   end
   always_comb begin
      w_next = r_state;
      case (r_state)
         HUNT:    if (w_new && i_rx_data == SYNC_BYTE) w_next = LEN;
         LEN:     if (w_new) w_next = w_len_ok ? PAY : HUNT; else if (w_tout) w_next = HUNT;
         PAY:     if (w_new && w_last) w_next = CSUM; else if (w_tout) w_next = HUNT;
         CSUM:    if (w_new) w_next = w_csum_ok ? DONE : HUNT; else if (w_tout) w_next = HUNT;
         DONE:    if (i_frame_ack) w_next = HUNT;
         default: w_next = HUNT;
      endcase
   end
   always_comb begin
      o_rx_ready_clear = r_consumed;
      o_frame_valid    = r_state == DONE;
      o_frame_len      = r_len;
      o_frame_rd_data  = r_buf[i_frame_rd_addr];
      o_csum_err       = r_csum_err;
      o_timeout_err    = r_tout_err;
      o_overrun_err    = r_ovr_err;
   end
   always_ff @(posedge i_sys_clk) begin
      if (!i_rst_n) begin
         r_consumed <= 1'b0;
         r_csum_err <= 1'b0;
         r_tout_err <= 1'b0;
         r_ovr_err  <= 1'b0;
         r_len      <= '0;
         r_idx      <= '0;
         r_acc      <= '0;
         r_tcnt     <= '0;
      end else begin
         // clear request stays up until the receiver has actually dropped rx_ready
         r_consumed <= w_new | (r_consumed & i_rx_ready);
         r_tcnt     <= (w_new | ~w_timed | w_tout) ? '0 : r_tcnt + 16'(i_rx_clk_en);
         r_csum_err <= w_new & (r_state == CSUM) & ~w_csum_ok;
         r_tout_err <= w_tout;
         r_ovr_err  <= w_new & (r_state == DONE);
         if (w_new && r_state == LEN && w_len_ok) begin
            r_len <= i_rx_data[3:0];
            r_acc <= i_rx_data;
            r_idx <= '0;
         end
         if (w_new && r_state == PAY) begin
            r_buf[r_idx] <= i_rx_data;
            r_acc        <= r_acc + i_rx_data;
            r_idx        <= r_idx + 3'd1;
         end
      end
   end
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb_uart_rx_frame_ctrl: acts as uart_receiver and consumer, checking the frame controller
// against a byte-level frame model using directed and randomized traffic.
module tb_uart_rx_frame_ctrl;
   localparam int TO = 2560;
   logic       clk = 0, rst_n = 0, en = 0, rdy = 0, ack = 0;
   logic [7:0] data = 0;
   logic [2:0] addr = 0;
   logic       clr, valid, cse, toe, ove;
   logic [3:0] flen;
   logic [7:0] rdd;
   int n_chk = 0, n_fail = 0;
   int ticks = 0, last_take = 0, n_cs = 0, n_to = 0, n_ov = 0, n_rise = 0, n_bytes = 0;
   logic prev_clr = 0;
   int mode = 0, plen = 0, exp_len = 0, exp_cs = 0, exp_to = 0, exp_ov = 0;
   bit held = 0;
   logic [7:0] q[$], exp_d[$];

   uart_rx_frame_ctrl dut (
      .i_sys_clk(clk), .i_rst_n(rst_n), .i_rx_clk_en(en), .i_rx_data(data), .i_rx_ready(rdy),
      .o_rx_ready_clear(clr), .o_frame_valid(valid), .o_frame_len(flen), .i_frame_rd_addr(addr),
      .o_frame_rd_data(rdd), .i_frame_ack(ack), .o_csum_err(cse), .o_timeout_err(toe),
      .o_overrun_err(ove)
   );

   always #10 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      ticks += int'(en);
      @(posedge clk);
      #1;
      n_cs += int'(cse);
      n_to += int'(toe);
      n_ov += int'(ove);
      if (clr && !prev_clr) n_rise++;
      prev_clr = clr;
      en = 1'($urandom_range(0, 1));
   endtask

   task automatic model_byte(input logic [7:0] b);
      logic [7:0] s;
      if (held) begin
         exp_ov++;
         return;
      end
      case (mode)
         0: if (b == 8'hA5) mode = 1;
         1: if (b >= 8'd1 && b <= 8'd8) begin plen = int'(b); q.delete(); mode = 2; end else mode = 0;
         2: begin q.push_back(b); if (q.size() == plen) mode = 3; end
         default: begin
            s = 8'(plen);
            foreach (q[i]) s += q[i];
            if (b == s) begin held = 1; exp_len = plen; exp_d = q; end
            else exp_cs++;
            mode = 0;
         end
      endcase
   endtask

   task automatic send_byte(input logic [7:0] b, input bit with_ack);
      bit was_held;
      was_held = held;
      data = b;
      rdy = 1;
      ack = with_ack;
      step();
      ack = 0;
      n_bytes++;
      last_take = ticks;
      model_byte(b);
      if (with_ack && was_held) held = 0;
      chk("take", clr, 1);
      chk("valid_lat", valid, held);
      repeat ($urandom_range(0, 3)) step();
      chk("clr_hold", clr, 1);
      rdy = 0;
      step();
      chk("clr_rel", clr, 0);
   endtask

   task automatic send_list(input logic [7:0] a[8], input int n);
      for (int i = 0; i < n; i++) send_byte(a[i], 0);
   endtask

   task automatic send_frame(input int len, input bit bad, input bit first_ack);
      logic [7:0] s, b;
      s = 8'(len);
      send_byte(8'hA5, first_ack);
      send_byte(8'(len), 0);
      for (int i = 0; i < len; i++) begin
         b = 8'($urandom);
         s += b;
         send_byte(b, 0);
      end
      send_byte(bad ? s ^ 8'(1 << $urandom_range(0, 7)) : s, 0);
   endtask

   task automatic do_ack();
      ack = 1;
      step();
      ack = 0;
      held = 0;
      chk("ack_valid", valid, 0);
   endtask

   task automatic wait_timeout();
      int k = 0, start = n_to;
      while (n_to == start && k < 20000) begin step(); k++; end
      chk("tout_ticks", ticks - last_take, TO);
      mode = 0;
      exp_to++;
      step();
      chk("tout_width", toe, 0);
   endtask

   task automatic check_all();
      chk("valid", valid, held);
      chk("csum_cnt", n_cs, exp_cs);
      chk("tout_cnt", n_to, exp_to);
      chk("ovr_cnt", n_ov, exp_ov);
      if (held) begin
         chk("len", flen, exp_len);
         for (int i = 0; i < exp_len; i++) begin
            addr = 3'(i);
            #1;
            chk("rd_data", rdd, exp_d[i]);
         end
      end
   endtask

   initial begin
      int ov0;
      logic [7:0] b;
      repeat (2) step();
      chk("rst_clr", clr, 0);
      chk("rst_valid", valid, 0);
      chk("rst_len", flen, 0);
      chk("rst_errs", {cse, toe, ove}, 0);
      rst_n = 1;
      step();
      send_list('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69, 8'h00, 8'h00}, 6);
      chk("t1_len", flen, 3);
      check_all();
      do_ack();
      send_list('{8'hA5, 8'h02, 8'h10, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00}, 5);
      chk("t2_valid", valid, 0);
      check_all();
      send_list('{8'hA5, 8'h01, 8'h7F, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00}, 4);
      addr = 0;
      #1;
      chk("t2_rd0", rdd, 8'h7F);
      check_all();
      do_ack();
      send_list('{8'hA5, 8'h02, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3);
      wait_timeout();
      send_frame(4, 0, 0);
      check_all();
      ov0 = n_ov;
      send_byte(8'h55, 0);
      chk("t4_ovr", n_ov - ov0, 1);
      check_all();
      do_ack();
      send_list('{8'h00, 8'hA5, 8'h09, 8'hA5, 8'h01, 8'h05, 8'h06, 8'h00}, 7);
      chk("t5_len", flen, 1);
      check_all();
      do_ack();
      send_list('{8'hA5, 8'h03, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3);
      data = 8'h22;
      rdy = 1;
      step();
      n_bytes++;
      chk("t6_take", clr, 1);
      rst_n = 0;
      rdy = 0;
      step();
      rst_n = 1;
      mode = 0;
      held = 0;
      chk("t6_clr", clr, 0);
      chk("t6_valid", valid, 0);
      chk("t6_len", flen, 0);
      chk("t6_errs", {cse, toe, ove}, 0);
      send_frame(5, 0, 0);
      check_all();
      for (int it = 0; it < 60; it++) begin
         if (held && $urandom_range(0, 3) != 0) do_ack();
         case ($urandom_range(0, 5))
            0, 1: send_frame($urandom_range(1, 8), 0, 1'($urandom_range(0, 1)));
            2: send_frame($urandom_range(1, 8), 1, 0);
            3: begin
               send_byte(8'hA5, 0);
               b = $urandom_range(0, 1) ? 8'h00 : 8'($urandom_range(9, 255));
               send_byte(b, 0);
            end
            4: send_byte(8'($urandom), 1'($urandom_range(0, 1)));
            default: if (it % 12 == 0) begin
               if (held) do_ack();
               send_byte(8'hA5, 0);
               send_byte(8'h02, 0);
               if (mode != 0) wait_timeout();
            end else if ($urandom_range(0, 1) == 1) do_ack();
         endcase
         check_all();
      end
      chk("takes", n_rise, n_bytes);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
